tpu_irq_ctrl: RTL and testbench

//  Interrupt controller directly downstream of the TPU timer. It consumes TPUINT as source 0 plus up to NUM_SRC-1 other TPU sources.

---
 rtl/tpu_irq_pkg.sv | 13 +
 rtl/tpu_irq_prio_enc.sv | 24 ++
 rtl/tpu_irq_ctrl.sv | 104 ++++++++++
 tb/tb_tpu_irq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_irq_pkg.sv
// Shared types and helpers for the TPU interrupt controller.
// Used by tpu_irq_ctrl and tpu_irq_prio_enc.
package tpu_irq_pkg;

  typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_SERVICE} irq_state_t;

  localparam int TIME_W = 7;

  function automatic int vec_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tpu_irq_prio_enc.sv
// Lowest-index-first priority encoder; purely combinational.
// idx is 0 when no request is present.
module tpu_irq_prio_enc
  import tpu_irq_pkg::*;
#(
  parameter int NUM_SRC = 4,
  localparam int VEC_W = vec_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [VEC_W-1:0]   idx,
  output logic               any
);

  // Scanning downward lets the lowest set index overwrite higher ones.
  always_comb begin
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = VEC_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/tpu_irq_ctrl.sv
// Edge-latching interrupt controller with REQ/ACK/EOI handshake to the CPU.
// Optional per-source timestamps when IRQ_STAMP_EN is defined.
module tpu_irq_ctrl
  import tpu_irq_pkg::*;
#(
  parameter int NUM_SRC = 4,
  localparam int VEC_W = vec_w(NUM_SRC)
) (
  input  logic               SYS_CLK,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] IRQ_SRC,
  input  logic [NUM_SRC-1:0] IRQ_MASK,
  input  logic [NUM_SRC-1:0] IRQ_CLR,
  output logic               INT_REQ,
  output logic [VEC_W-1:0]   INT_VEC,
  input  logic               INT_ACK,
  input  logic               INT_EOI,
  output logic [NUM_SRC-1:0] PENDING,
`ifdef IRQ_STAMP_EN
  input  logic [TIME_W-1:0]  TIME,
  output logic [TIME_W-1:0]  INT_STAMP,
`endif
  output logic               INTFLAG
);

  irq_state_t         state, state_nx;
  logic [VEC_W-1:0]   vec, vec_nx;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending, pending_nx;
  logic [NUM_SRC-1:0] set_mask, ack_clr;
  logic [VEC_W-1:0]   enc_idx;
  logic               enc_any;
  logic               ack_ok;

  assign set_mask   = IRQ_SRC & ~src_q & IRQ_MASK;
  assign ack_ok     = (state == IRQ_REQ) && INT_ACK;
  assign ack_clr    = ack_ok ? (NUM_SRC'(1) << vec) : '0;
  // A new edge in the same cycle as a clear keeps the source pending.
  assign pending_nx = set_mask | (pending & ~(IRQ_CLR | ack_clr));

  tpu_irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
    .req (pending & IRQ_MASK),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    state_nx = state;
    vec_nx   = vec;
    case (state)
      IRQ_IDLE: begin
        if (enc_any) begin
          state_nx = IRQ_REQ;
          vec_nx   = enc_idx;
        end
      end
      IRQ_REQ: begin
        // ACK takes priority over a withdrawal seen in the same cycle.
        if (INT_ACK) state_nx = IRQ_SERVICE;
        else if (!pending_nx[vec] || !IRQ_MASK[vec]) state_nx = IRQ_IDLE;
      end
      IRQ_SERVICE: begin
        if (INT_EOI) state_nx = IRQ_IDLE;
      end
      default: state_nx = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IRQ_IDLE;
      vec     <= '0;
      src_q   <= '0;
      pending <= '0;
    end else begin
      state   <= state_nx;
      vec     <= vec_nx;
      src_q   <= IRQ_SRC;
      pending <= pending_nx;
    end
  end

  assign INT_REQ = (state == IRQ_REQ);
  assign INT_VEC = vec;
  assign PENDING = pending;
  assign INTFLAG = pending[0];

`ifdef IRQ_STAMP_EN
  logic [TIME_W-1:0] stamp [NUM_SRC];

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_SRC; i++) stamp[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (set_mask[i]) stamp[i] <= TIME;
      end
    end
  end

  assign INT_STAMP = (state == IRQ_IDLE) ? '0 : stamp[vec];
`endif

endmodule

// File: tb/tb_tpu_irq_ctrl.sv
// Directed and randomized checks of tpu_irq_ctrl against a cycle-level reference model.
// Build with IRQ_STAMP_EN defined to also cover the timestamp outputs.
module tb_tpu_irq_ctrl;

  logic       SYS_CLK = 1'b0;
  logic       RST_N;
  logic [3:0] IRQ_SRC, IRQ_MASK, IRQ_CLR;
  logic       INT_ACK, INT_EOI;
  logic       INT_REQ;
  logic [1:0] INT_VEC;
  logic [3:0] PENDING;
  logic       INTFLAG;
`ifdef IRQ_STAMP_EN
  logic [6:0] TIME;
  logic [6:0] INT_STAMP;
`endif

  tpu_irq_ctrl #(.NUM_SRC(4)) dut (
    .SYS_CLK (SYS_CLK),
    .RST_N   (RST_N),
    .IRQ_SRC (IRQ_SRC),
    .IRQ_MASK(IRQ_MASK),
    .IRQ_CLR (IRQ_CLR),
    .INT_REQ (INT_REQ),
    .INT_VEC (INT_VEC),
    .INT_ACK (INT_ACK),
    .INT_EOI (INT_EOI),
    .PENDING (PENDING),
`ifdef IRQ_STAMP_EN
    .TIME    (TIME),
    .INT_STAMP(INT_STAMP),
`endif
    .INTFLAG (INTFLAG)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int total = 0;
  int bad   = 0;
  string cur_tag = "reset";

  // Reference model: 0 = idle, 1 = requesting, 2 = in service
  bit m_pend [4];
  bit m_srcq [4];
  int m_state;
  int m_vec;
  int m_stamp [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s/%s got=%0h exp=%0h", cur_tag, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_vec   = 0;
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0; m_srcq[i] = 0; m_stamp[i] = 0;
    end
  endtask

  task automatic check_model();
    logic [3:0] exp_pend;
    for (int i = 0; i < 4; i++) exp_pend[i] = m_pend[i];
    chk("pending", PENDING, exp_pend);
    chk("intflag", INTFLAG, exp_pend[0]);
    chk("int_req", INT_REQ, (m_state == 1));
    if (m_state != 0) chk("int_vec", INT_VEC, m_vec);
`ifdef IRQ_STAMP_EN
    chk("int_stamp", INT_STAMP, (m_state == 0) ? 0 : m_stamp[m_vec]);
`endif
  endtask

  // Advance one clock with the currently driven inputs, then compare against the model.
  task automatic tick();
    bit np [4];
    bit setv [4];
    bit ack_ok;
    int ns, nv, first;
    ack_ok = (m_state == 1) && INT_ACK;
    for (int i = 0; i < 4; i++) begin
      setv[i] = IRQ_SRC[i] && !m_srcq[i] && IRQ_MASK[i];
      if (setv[i]) np[i] = 1;
      else if (IRQ_CLR[i] || (ack_ok && i == m_vec)) np[i] = 0;
      else np[i] = m_pend[i];
    end
    ns = m_state; nv = m_vec;
    if (m_state == 0) begin
      first = -1;
      for (int i = 0; i < 4; i++)
        if (first < 0 && m_pend[i] && IRQ_MASK[i]) first = i;
      if (first >= 0) begin ns = 1; nv = first; end
    end else if (m_state == 1) begin
      if (INT_ACK) ns = 2;
      else if (!np[m_vec] || !IRQ_MASK[m_vec]) ns = 0;
    end else begin
      if (INT_EOI) ns = 0;
    end
    @(posedge SYS_CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = np[i];
      m_srcq[i] = IRQ_SRC[i];
`ifdef IRQ_STAMP_EN
      if (setv[i]) m_stamp[i] = TIME;
`endif
    end
    m_state = ns; m_vec = nv;
    IRQ_CLR = '0; INT_ACK = 1'b0; INT_EOI = 1'b0;
    check_model();
  endtask

  task automatic drain();
    IRQ_SRC = '0;
    for (int k = 0; k < 8; k++) begin
      if (m_state == 1) INT_ACK = 1'b1;
      else if (m_state == 2) INT_EOI = 1'b1;
      IRQ_CLR = 4'hF;
      tick();
    end
  endtask

  initial begin
    RST_N = 1'b0; IRQ_SRC = '0; IRQ_MASK = 4'hF; IRQ_CLR = '0;
    INT_ACK = 1'b0; INT_EOI = 1'b0;
`ifdef IRQ_STAMP_EN
    TIME = '0;
`endif
    model_reset();
    #12;
    chk("rst_req", INT_REQ, 0);
    chk("rst_pend", PENDING, 0);
    chk("rst_flag", INTFLAG, 0);
    chk("rst_vec", INT_VEC, 0);
    RST_N = 1'b1;
    tick();

    cur_tag = "t1_timer";
    drain();
    IRQ_SRC = 4'b0001; tick();
    chk("flag_set", INTFLAG, 1); chk("no_req_yet", INT_REQ, 0);
    IRQ_SRC = '0; tick();
    chk("req", INT_REQ, 1); chk("vec0", INT_VEC, 0);
    INT_ACK = 1'b1; tick();
    chk("req_after_ack", INT_REQ, 0); chk("flag_after_ack", INTFLAG, 0);
    INT_EOI = 1'b1; tick();
    tick();
    chk("idle_after_eoi", INT_REQ, 0);

    cur_tag = "t2_prio";
    drain();
    IRQ_SRC = 4'b0110; tick();
    IRQ_SRC = '0; tick();
    chk("first_vec", INT_VEC, 1); chk("first_req", INT_REQ, 1);
    INT_ACK = 1'b1; tick();
    INT_EOI = 1'b1; tick();
    chk("gap_idle", INT_REQ, 0);
    tick();
    chk("second_req", INT_REQ, 1); chk("second_vec", INT_VEC, 2);

    cur_tag = "t3_nopreempt";
    drain();
    IRQ_SRC = 4'b0100; tick();
    IRQ_SRC = '0; tick();
    chk("vec2", INT_VEC, 2);
    IRQ_SRC = 4'b0001; tick();
    chk("still_vec2", INT_VEC, 2); chk("still_req", INT_REQ, 1);
    IRQ_SRC = '0; INT_ACK = 1'b1; tick();
    INT_EOI = 1'b1; tick();
    tick();
    chk("then_vec0", INT_VEC, 0); chk("then_req", INT_REQ, 1);

    cur_tag = "t4_mask";
    drain();
    IRQ_MASK = 4'h7; IRQ_SRC = 4'b1000; tick();
    chk("masked_pend3", PENDING[3], 0);
    IRQ_MASK = 4'hF; tick(); tick();
    chk("level_no_req", INT_REQ, 0);
    IRQ_SRC = '0; tick();

    cur_tag = "t5_clr";
    drain();
    IRQ_SRC = 4'b0010; tick();
    IRQ_SRC = '0; tick();
    chk("vec1", INT_VEC, 1);
    IRQ_CLR = 4'b0010; tick();
    chk("withdraw", INT_REQ, 0);
    IRQ_SRC = 4'b0010; IRQ_CLR = 4'b0010; tick();
    chk("set_wins", PENDING[1], 1);
    IRQ_SRC = '0;

    cur_tag = "t6_reset";
    drain();
    IRQ_SRC = 4'b0010; tick();
    IRQ_SRC = '0; tick();
    INT_ACK = 1'b1; tick();
    IRQ_SRC = 4'b0001; tick();
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    chk("arst_req", INT_REQ, 0); chk("arst_pend", PENDING, 0);
    chk("arst_flag", INTFLAG, 0); chk("arst_vec", INT_VEC, 0);
    IRQ_SRC = '0;
    #2 RST_N = 1'b1;
    INT_EOI = 1'b1; tick();
    tick();
    chk("stray_eoi", INT_REQ, 0);

`ifdef IRQ_STAMP_EN
    cur_tag = "t7_stamp";
    drain();
    TIME = 7'h2A; IRQ_SRC = 4'b1000; tick();
    TIME = 7'h05; IRQ_SRC = '0; tick();
    chk("stamp_2a", INT_STAMP, 7'h2A);
    drain();
`endif

    cur_tag = "random";
    for (int c = 0; c < 600; c++) begin
      IRQ_SRC = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        IRQ_MASK[i] = ($urandom_range(0, 7) != 0);
        IRQ_CLR[i]  = ($urandom_range(0, 9) == 0);
      end
      INT_ACK = ($urandom_range(0, 2) == 0);
      INT_EOI = ($urandom_range(0, 2) == 0);
`ifdef IRQ_STAMP_EN
      TIME = 7'($urandom_range(0, 127));
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
